// File: rtl/mod_n_toggle_counter.sv
// Modulo-(mod_val+1) up/down counter. It has a synchronous load, a registered
// terminal-count pulse and a built-in T flip-flop that divides the wrap rate by two.
module mod_n_toggle_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             div_q
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_div_q;

    // Wrap conditions. A count above mod_val also wraps when counting up.
    logic             w_up_wrap;
    logic             w_down_wrap;
    logic             w_wrap;
    logic [WIDTH-1:0] w_step;

    // Select the wrap condition and the next non-wrapping value for the current direction.
    always_comb begin
        w_up_wrap   = (r_count >= mod_val);
        w_down_wrap = (r_count == WIDTH'(0));
        w_wrap      = up ? w_up_wrap : w_down_wrap;
        w_step      = up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
    end

    // State update. Priority is reset, then load, then enable, then hold.
    // A wrap clears or presets the count, raises tc for one cycle and toggles div_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_div_q <= 1'b0;
        end else if (load) begin
            r_count <= load_val;
            r_tc    <= 1'b0;
        end else if (en) begin
            if (w_wrap) begin
                r_count <= up ? WIDTH'(0) : mod_val;
                r_tc    <= 1'b1;
                r_div_q <= ~r_div_q;
            end else begin
                r_count <= w_step;
                r_tc    <= 1'b0;
            end
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign div_q = r_div_q;

endmodule

// File: tb/tb_mod_n_toggle_counter.sv
// Randomised and directed bench for mod_n_toggle_counter.
// A driver pushes expected results into a scoreboard queue, and a monitor pops and checks them.
module tb_mod_n_toggle_counter;

    localparam int unsigned WIDTH = 4;
    localparam int          MODV  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             up = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] mod_val = '0;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             div_q;

    mod_n_toggle_counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .mod_val  (mod_val),
        .count    (count),
        .tc       (tc),
        .div_q    (div_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    count;
        int    tc;
        int    div_q;
        string tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state. div_q is the parity of the number of wraps since reset.
    int m_count = 0;
    int m_wraps = 0;
    int m_tc    = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus, advance the reference model and queue the expected outputs.
    task automatic step(input bit r, input bit e, input bit u, input bit l,
                        input int lv, input int mv, input string tag);
        exp_t x;
        @(negedge clk);
        rst      = r;
        en       = e;
        up       = u;
        load     = l;
        load_val = WIDTH'(lv);
        mod_val  = WIDTH'(mv);
        if (r) begin
            m_count = 0; m_tc = 0; m_wraps = 0;
        end else if (l) begin
            m_count = lv % MODV; m_tc = 0;
        end else if (e) begin
            if (u) begin
                // The period is mod_val+1. Any value at or beyond the terminal value returns to 0.
                if (m_count >= mv) begin m_count = 0; m_tc = 1; m_wraps++; end
                else begin m_count = m_count + 1; m_tc = 0; end
            end else begin
                if (m_count == 0) begin m_count = mv; m_tc = 1; m_wraps++; end
                else begin m_count = m_count - 1; m_tc = 0; end
            end
        end else begin
            m_tc = 0;
        end
        x.count = m_count;
        x.tc    = m_tc;
        x.div_q = m_wraps % 2;
        x.tag   = tag;
        q.push_back(x);
    endtask

    // Monitor: every clock edge produces a new output, so check it 1ns after the edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk({x.tag, ".count"}, int'(count), x.count);
                chk({x.tag, ".tc"},    int'(tc),    x.tc);
                chk({x.tag, ".div_q"}, int'(div_q), x.div_q);
            end
        end
    end

    initial begin
        int lv;
        int mv;
        int budget;

        // Reset held for 2 cycles while en and load are high.
        step(1, 1, 1, 1, 7, 4, "reset");
        step(1, 1, 1, 1, 7, 4, "reset");

        // Up wrap with mod 4. Expected count 1,2,3,4,0,... and div_q toggles at the 5th and 10th edges.
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 4, "upwrap");

        // Down wrap with mod 5, starting from reset.
        step(1, 0, 0, 0, 0, 5, "rst");
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 5, "downwrap");

        // Load a value above the modulus, then count up.
        step(1, 0, 1, 0, 0, 3, "rst");
        step(0, 0, 1, 1, 9, 3, "loadhi");
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 3, "loadhi_up");
        // Load above the modulus, then count down.
        step(0, 0, 0, 1, 6, 3, "loadhi_dn");
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 3, "loadhi_dn");

        // Degenerate modulus: with mod_val 0, every enabled edge wraps.
        step(1, 0, 1, 0, 0, 0, "rst");
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 0, "mod0");

        // Interruptions: hold, load beating en, and reset in mid-count.
        step(1, 0, 1, 0, 0, 3, "rst");
        step(0, 1, 1, 0, 0, 3, "intr");
        step(0, 1, 1, 0, 0, 3, "intr");
        step(0, 0, 1, 0, 0, 3, "hold");
        step(0, 0, 0, 0, 0, 3, "hold");
        step(0, 1, 1, 1, 1, 3, "loadwins");
        step(0, 1, 1, 0, 0, 3, "intr");
        step(0, 1, 1, 0, 0, 3, "intr");
        step(1, 1, 1, 0, 0, 3, "rst_mid");
        step(0, 1, 1, 0, 0, 3, "after_rst");
        // A direction change in mid-count.
        step(0, 1, 0, 0, 0, 3, "dirchg");
        step(0, 1, 1, 0, 0, 3, "dirchg");

        // Randomised traffic, which includes live changes of mod_val.
        mv = 6;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) mv = $urandom_range(0, MODV - 1);
            lv = $urandom_range(0, MODV - 1);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 8,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 14) == 0,
                 lv, mv, "rand");
        end

        // Wait for the monitor to empty the scoreboard.
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
